// File: rtl/matrix_mac_pkg.sv
// rtl/matrix_mac_pkg.sv - shared types and width helpers for the matrix MAC sequencer
package matrix_mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT,
        EMIT,
        DONE
    } state_t;

    localparam logic MAT_A = 1'b0;
    localparam logic MAT_B = 1'b1;

    // Ceiling log2, never below 1 so that index ports always have at least one bit.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

    function automatic int acc_width(input int data_width, input int dim);
        return 2 * data_width + clog2(dim);
    endfunction

endpackage

// File: rtl/matrix_mac_sequencer_if.sv
// rtl/matrix_mac_sequencer_if.sv - MAC datapath and result stream bundle
interface matrix_mac_sequencer_if
    import matrix_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIM        = 4,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, DIM)
);
    localparam int IDX_WIDTH = clog2(DIM);

    logic                  mac_clear;
    logic                  mac_enable;
    logic [DATA_WIDTH-1:0] mac_operand_1;
    logic [DATA_WIDTH-1:0] mac_operand_2;
    logic [ACC_WIDTH-1:0]  mac_result;

    logic                  res_valid;
    logic                  res_ready;
    logic [ACC_WIDTH-1:0]  res_data;
    logic [IDX_WIDTH-1:0]  res_row;
    logic [IDX_WIDTH-1:0]  res_col;
    logic                  res_last;

    modport master (
        output mac_clear, mac_enable, mac_operand_1, mac_operand_2,
        input  mac_result,
        output res_valid, res_data, res_row, res_col, res_last,
        input  res_ready
    );

    modport slave (
        input  mac_clear, mac_enable, mac_operand_1, mac_operand_2,
        output mac_result,
        input  res_valid, res_data, res_row, res_col, res_last,
        output res_ready
    );

endinterface

// File: rtl/matrix_operand_bank.sv
// rtl/matrix_operand_bank.sv - DIM*DIM operand register array, one write and one async read port
module matrix_operand_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; operands survive a sequencer abort.
    always_ff @(posedge clock) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/matrix_mac_sequencer.sv
// rtl/matrix_mac_sequencer.sv - drives the MAC through C = A x B and streams results; MAC_SEQ_STALL_CNT_EN adds stall_count
module matrix_mac_sequencer
    import matrix_mac_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DIM         = 4,
    parameter int ACC_WIDTH   = acc_width(DATA_WIDTH, DIM),
    parameter int MAC_LATENCY = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    input  logic                          load_we,
    input  logic                          load_sel,
    input  logic [clog2(DIM*DIM)-1:0]     load_addr,
    input  logic [DATA_WIDTH-1:0]         load_data,
    matrix_mac_sequencer_if.master        bus
`ifdef MAC_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_count
`endif
);

    localparam int IDX_WIDTH  = clog2(DIM);
    localparam int ADDR_WIDTH = clog2(DIM * DIM);
    localparam int WAIT_WIDTH = clog2(MAC_LATENCY + 1);

    localparam logic [IDX_WIDTH-1:0]  IDX_LAST  = IDX_WIDTH'(DIM - 1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(MAC_LATENCY - 1);

    state_t                 state;
    logic [IDX_WIDTH-1:0]   i;
    logic [IDX_WIDTH-1:0]   j;
    logic [IDX_WIDTH-1:0]   k;
    logic [WAIT_WIDTH-1:0]  wait_cnt;

    logic [IDX_WIDTH-1:0]   rd_k;
    logic [ADDR_WIDTH-1:0]  addr_a;
    logic [ADDR_WIDTH-1:0]  addr_b;
    logic [DATA_WIDTH-1:0]  data_a;
    logic [DATA_WIDTH-1:0]  data_b;
    logic                   we_a;
    logic                   we_b;

    assign we_a = load_we && (state == IDLE) && (load_sel == MAT_A);
    assign we_b = load_we && (state == IDLE) && (load_sel == MAT_B);

    // Operands are registered, so the banks are read one step ahead of the
    // k that the MAC will see on the following cycle.
    assign rd_k   = (state == CLEAR) ? '0 : k + 1'b1;
    assign addr_a = ADDR_WIDTH'(i) * ADDR_WIDTH'(DIM) + ADDR_WIDTH'(rd_k);
    assign addr_b = ADDR_WIDTH'(rd_k) * ADDR_WIDTH'(DIM) + ADDR_WIDTH'(j);

    matrix_operand_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DIM * DIM),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank_a (
        .clock (clock),
        .we    (we_a),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (addr_a),
        .rdata (data_a)
    );

    matrix_operand_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DIM * DIM),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank_b (
        .clock (clock),
        .we    (we_b),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (addr_b),
        .rdata (data_b)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            i                 <= '0;
            j                 <= '0;
            k                 <= '0;
            wait_cnt          <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            bus.mac_clear     <= 1'b0;
            bus.mac_enable    <= 1'b0;
            bus.mac_operand_1 <= '0;
            bus.mac_operand_2 <= '0;
            bus.res_valid     <= 1'b0;
            bus.res_data      <= '0;
            bus.res_row       <= '0;
            bus.res_col       <= '0;
            bus.res_last      <= 1'b0;
`ifdef MAC_SEQ_STALL_CNT_EN
            stall_count       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state         <= CLEAR;
                        busy          <= 1'b1;
                        i             <= '0;
                        j             <= '0;
                        bus.mac_clear <= 1'b1;
`ifdef MAC_SEQ_STALL_CNT_EN
                        stall_count   <= '0;
`endif
                    end
                end
                CLEAR: begin
                    state             <= FEED;
                    k                 <= '0;
                    bus.mac_clear     <= 1'b0;
                    bus.mac_enable    <= 1'b1;
                    bus.mac_operand_1 <= data_a;
                    bus.mac_operand_2 <= data_b;
                end
                FEED: begin
                    if (k == IDX_LAST) begin
                        state             <= WAIT;
                        wait_cnt          <= '0;
                        bus.mac_enable    <= 1'b0;
                        bus.mac_operand_1 <= '0;
                        bus.mac_operand_2 <= '0;
                    end else begin
                        k                 <= k + 1'b1;
                        bus.mac_operand_1 <= data_a;
                        bus.mac_operand_2 <= data_b;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state         <= EMIT;
                        bus.res_valid <= 1'b1;
                        bus.res_data  <= bus.mac_result;
                        bus.res_row   <= i;
                        bus.res_col   <= j;
                        bus.res_last  <= (i == IDX_LAST) && (j == IDX_LAST);
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        if (bus.res_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state         <= CLEAR;
                            bus.mac_clear <= 1'b1;
                            if (j == IDX_LAST) begin
                                j <= '0;
                                i <= i + 1'b1;
                            end else begin
                                j <= j + 1'b1;
                            end
                        end
                    end
`ifdef MAC_SEQ_STALL_CNT_EN
                    else if (stall_count != 16'hFFFF) begin
                        stall_count <= stall_count + 16'd1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
